dm_responder: RTL and testbench

Data-memory responder on the processor's load/store port: the memory-side end of the interface the core drives with `DmWr`, `DmCtrl`, the ALU-computed address and `ru_RS2` store data. It accepts one request at a time and inserts a configurable number of wait states. It performs byte, halfword and word stores with lane merging, and returns sign- or zero-extended load data with a `ready` handshake. It replaces the zero-latency combinational data memory when the core moves to a stall-capable memory path.

---
 rtl/dm_pkg.sv | 31 +++
 rtl/dm_responder_if.sv | 38 +++
 rtl/dm_lane_align.sv | 106 ++++++++++
 rtl/dm_responder.sv | 176 +++++++++++++++++
 tb/tb_dm_responder.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// ============================================================================
// Module      : dm_pkg
// Description : Shared types and constants for the data-memory responder:
//               load/store access encodings (funct3), FSM state encoding and
//               the wait-state counter width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dm_pkg;

   // Access type, funct3 encoding as driven on DmCtrl. 011/110/111 are illegal.
   typedef enum logic [2:0] {
      DM_B  = 3'b000,
      DM_H  = 3'b001,
      DM_W  = 3'b010,
      DM_BU = 3'b100,
      DM_HU = 3'b101
   } dm_ctrl_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dm_state_e;

   localparam int CNT_W = 4;

endpackage : dm_pkg

`default_nettype wire

// File: rtl/dm_responder_if.sv
// ============================================================================
// Module      : dm_responder_if
// Description : Load/store port between the core (master) and the data-memory
//               responder (slave).
//   req     master->slave  request valid, held with all fields until ready
//   DmWr    master->slave  1 = store, 0 = load
//   DmCtrl  master->slave  access type (funct3)
//   Address master->slave  byte address
//   DataWr  master->slave  store data
//   ready   slave->master  one-cycle response pulse
//   DataRd  slave->master  load result, 0 unless ready
//   err     slave->master  error flag, valid with ready
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dm_responder_if;
   logic        req;
   logic        DmWr;
   logic [2:0]  DmCtrl;
   logic [31:0] Address;
   logic [31:0] DataWr;
   logic        ready;
   logic [31:0] DataRd;
   logic        err;

   modport master (
      output req, DmWr, DmCtrl, Address, DataWr,
      input  ready, DataRd, err
   );

   modport slave (
      input  req, DmWr, DmCtrl, Address, DataWr,
      output ready, DataRd, err
   );
endinterface : dm_responder_if

`default_nettype wire

// File: rtl/dm_lane_align.sv
// ============================================================================
// Module      : dm_lane_align
// Description : Combinational byte-lane steering for the data-memory responder.
//               Store path: byte enables and lane-replicated write data.
//               Load path : lane extraction with sign/zero extension.
//               Also flags illegal (and optionally misaligned) accesses; on an
//               error the byte enables and load data are forced to zero.
//   ctrl      in  3   access type (funct3)
//   wr        in  1   1 = store
//   addr_lo   in  2   byte offset within the word
//   wdata     in  32  raw store data
//   rword     in  32  addressed memory word
//   be        out 4   byte enables
//   wdata_rep out 32  store data replicated across lanes
//   rdata     out 32  extended load data
//   err       out 1   access error
// Config macro: DM_MISALIGN_ERR_EN - misaligned H/HU/W report err instead of
//               being aligned down.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_lane_align
   import dm_pkg::*;
(
   input  logic [2:0]  ctrl,
   input  logic        wr,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata,
   output logic        err
);

   logic [1:0]  lane;
   logic        illegal;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      lane      = addr_lo;
      illegal   = 1'b0;
      be        = 4'b0000;
      wdata_rep = wdata;
      rdata     = '0;
      err       = 1'b0;

      // Halfword/word accesses ignore the offending low bits: aligned down.
      case (ctrl)
         DM_B, DM_BU: lane = addr_lo;
         DM_H, DM_HU: lane = {addr_lo[1], 1'b0};
         DM_W:        lane = 2'b00;
         default:     illegal = 1'b1;
      endcase

      // Unsigned variants only make sense for loads.
      if (wr && ((ctrl == DM_BU) || (ctrl == DM_HU))) begin
         illegal = 1'b1;
      end

`ifdef DM_MISALIGN_ERR_EN
      err = illegal
          | (((ctrl == DM_H) || (ctrl == DM_HU)) && addr_lo[0])
          | ((ctrl == DM_W) && (addr_lo != 2'b00));
`else
      err = illegal;
`endif

      sel_byte = rword[8*lane +: 8];
      sel_half = rword[16*lane[1] +: 16];

      case (ctrl)
         DM_B: begin
            be        = 4'b0001 << lane;
            wdata_rep = {4{wdata[7:0]}};
            rdata     = {{24{sel_byte[7]}}, sel_byte};
         end
         DM_BU: rdata = {24'd0, sel_byte};
         DM_H: begin
            be        = lane[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            rdata     = {{16{sel_half[15]}}, sel_half};
         end
         DM_HU: rdata = {16'd0, sel_half};
         DM_W: begin
            be        = 4'b1111;
            wdata_rep = wdata;
            rdata     = rword;
         end
         default: begin
            be    = 4'b0000;
            rdata = '0;
         end
      endcase

      if (err) begin
         be    = 4'b0000;
         rdata = '0;
      end
   end

endmodule : dm_lane_align

`default_nettype wire

// File: rtl/dm_responder.sv
// ============================================================================
// Module      : dm_responder
// Description : Data-memory responder for the core's load/store port. Accepts
//               one request at a time, inserts WAIT_CYCLES wait states, then
//               performs the access and returns a one-cycle ready pulse.
//   clk    in  1   clock, rising edge
//   rst_n  in  1   asynchronous active-low reset
//   bus    slave   dm_responder_if (req/DmWr/DmCtrl/Address/DataWr in,
//                  ready/DataRd/err out)
// Parameters : DEPTH_WORDS (power of two), WAIT_CYCLES (0..15)
// Config macro: DM_MISALIGN_ERR_EN (handled in dm_lane_align)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_responder
   import dm_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   dm_responder_if.slave bus
);

   localparam int              AW        = $clog2(DEPTH_WORDS);
   localparam bit              NO_WAIT   = (WAIT_CYCLES == 0);
   localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   dm_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_q, wr_d;
   logic [2:0]       ctrl_q, ctrl_d;
   logic [AW+1:0]    addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             err_q, err_d;

   logic [31:0]      mem [DEPTH_WORDS];

   // Access-side view of the request: with no wait states the access happens
   // on the accepting edge, so it must use the live bus fields.
   logic             acc_en;
   logic             acc_wr;
   logic [2:0]       acc_ctrl;
   logic [AW+1:0]    acc_addr;
   logic [31:0]      acc_wdata;
   logic [AW-1:0]    acc_idx;
   logic [31:0]      rword;
   logic [3:0]       be;
   logic [31:0]      wdata_rep;
   logic [31:0]      ld_data;
   logic             acc_err;

   // Upper address bits are ignored: addresses wrap modulo the memory size.
   logic             unused_addr_hi;
   assign unused_addr_hi = ^bus.Address[31:AW+2];

   always_comb begin
      acc_en    = 1'b0;
      acc_wr    = wr_q;
      acc_ctrl  = ctrl_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      if (NO_WAIT) begin
         acc_en    = (state_q == ST_IDLE) && bus.req;
         acc_wr    = bus.DmWr;
         acc_ctrl  = bus.DmCtrl;
         acc_addr  = bus.Address[AW+1:0];
         acc_wdata = bus.DataWr;
      end else begin
         acc_en    = (state_q == ST_WAIT) && (cnt_q == '0);
      end
   end

   assign acc_idx = acc_addr[AW+1:2];
   assign rword   = mem[acc_idx];

   dm_lane_align u_lane_align (
      .ctrl      (acc_ctrl),
      .wr        (acc_wr),
      .addr_lo   (acc_addr[1:0]),
      .wdata     (acc_wdata),
      .rword     (rword),
      .be        (be),
      .wdata_rep (wdata_rep),
      .rdata     (ld_data),
      .err       (acc_err)
   );

   // Next-state and request-latch logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      ctrl_d  = ctrl_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.req) begin
               wr_d    = bus.DmWr;
               ctrl_d  = bus.DmCtrl;
               addr_d  = bus.Address[AW+1:0];
               wdata_d = bus.DataWr;
               if (NO_WAIT) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Response payload is captured on the access edge; stores return 0.
      if (acc_en) begin
         rdata_d = acc_wr ? 32'd0 : ld_data;
         err_d   = acc_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         ctrl_q  <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         ctrl_q  <= ctrl_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Memory is not reset. The write enable derives from reset-cleared state,
   // so a store pending in WAIT is dropped by reset.
   always_ff @(posedge clk) begin
      if (acc_en && acc_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[acc_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
         end
      end
   end

   assign bus.ready  = (state_q == ST_RESP);
   assign bus.DataRd = (state_q == ST_RESP) ? rdata_q : 32'd0;
   assign bus.err    = (state_q == ST_RESP) && err_q;

endmodule : dm_responder

`default_nettype wire

// File: tb/tb_dm_responder.sv
// ============================================================================
// Module      : tb_dm_responder
// Description : Self-checking bench for dm_responder. Instance A runs with
//               WAIT_CYCLES=2, instance B with WAIT_CYCLES=0. Expected
//               responses are queued when a request is driven and compared
//               when ready is seen. Expectations follow DM_MISALIGN_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_responder;

   localparam logic [2:0] C_B = 3'b000, C_H = 3'b001, C_W = 3'b010;
   localparam logic [2:0] C_BU = 3'b100, C_HU = 3'b101;

   typedef struct {
      logic        wr;
      logic [2:0]  ctrl;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_d;
      logic        exp_e;
   } vec_t;

   typedef struct packed {
      logic [31:0] d;
      logic        e;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   exp_t sb_a[$];
   exp_t sb_b[$];
   vec_t va[$];
   vec_t vb[$];

   dm_responder_if a_if ();
   dm_responder_if b_if ();

   dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .bus(a_if.slave)
   );
   dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .bus(b_if.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_d, input logic exp_e);
      vec_t v;
      v.wr = wr; v.ctrl = ctrl; v.addr = addr; v.wdata = wdata; v.exp_d = exp_d; v.exp_e = exp_e;
      return v;
   endfunction

   // Response monitors: pop on ready, otherwise outputs must be idle-zero.
   always @(negedge clk) begin
      exp_t e;
      checks++;
      if (a_if.ready) begin
         if (sb_a.size() == 0) begin
            errors++;
            $display("FAIL a_unexpected_ready DataRd=%h err=%b", a_if.DataRd, a_if.err);
         end else begin
            e = sb_a.pop_front();
            if (a_if.DataRd !== e.d || a_if.err !== e.e) begin
               errors++;
               $display("FAIL a_resp got DataRd=%h err=%b want DataRd=%h err=%b",
                        a_if.DataRd, a_if.err, e.d, e.e);
            end
         end
      end else if (a_if.DataRd !== 32'd0 || a_if.err !== 1'b0) begin
         errors++;
         $display("FAIL a_idle_outputs got DataRd=%h err=%b want 0", a_if.DataRd, a_if.err);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      checks++;
      if (b_if.ready) begin
         if (sb_b.size() == 0) begin
            errors++;
            $display("FAIL b_unexpected_ready DataRd=%h err=%b", b_if.DataRd, b_if.err);
         end else begin
            e = sb_b.pop_front();
            if (b_if.DataRd !== e.d || b_if.err !== e.e) begin
               errors++;
               $display("FAIL b_resp got DataRd=%h err=%b want DataRd=%h err=%b",
                        b_if.DataRd, b_if.err, e.d, e.e);
            end
         end
      end else if (b_if.DataRd !== 32'd0 || b_if.err !== 1'b0) begin
         errors++;
         $display("FAIL b_idle_outputs got DataRd=%h err=%b want 0", b_if.DataRd, b_if.err);
      end
   end

   // One transaction: drive, queue expectation, wait (bounded) for ready,
   // check latency counted in cycles after the accepting edge.
   task automatic txn(input bit sel, input vec_t v, input int exp_lat);
      int   n;
      exp_t e;
      e.d = v.exp_d;
      e.e = v.exp_e;
      @(negedge clk);
      if (sel) begin
         b_if.req = 1'b1; b_if.DmWr = v.wr; b_if.DmCtrl = v.ctrl;
         b_if.Address = v.addr; b_if.DataWr = v.wdata;
         sb_b.push_back(e);
      end else begin
         a_if.req = 1'b1; a_if.DmWr = v.wr; a_if.DmCtrl = v.ctrl;
         a_if.Address = v.addr; a_if.DataWr = v.wdata;
         sb_a.push_back(e);
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (((sel ? b_if.ready : a_if.ready) == 1'b0) && n < 20);
      checks++;
      if (n != exp_lat) begin
         errors++;
         $display("FAIL latency inst=%0d addr=%h got %0d cycles want %0d", sel, v.addr, n, exp_lat);
      end
      if (sel) b_if.req = 1'b0;
      else     a_if.req = 1'b0;
   endtask

   initial begin
      int   n;
      int   pulses;
      exp_t e;
      a_if.req = 1'b0; a_if.DmWr = 1'b0; a_if.DmCtrl = 3'b000; a_if.Address = '0; a_if.DataWr = '0;
      b_if.req = 1'b0; b_if.DmWr = 1'b0; b_if.DmCtrl = 3'b000; b_if.Address = '0; b_if.DataWr = '0;

      // ---------------- vector tables ----------------
      va.push_back(mk(1, C_W,  32'h10, 32'hDEADBEEF, 32'h0,        0));
      va.push_back(mk(0, C_W,  32'h10, 32'h0,        32'hDEADBEEF, 0));
      va.push_back(mk(1, C_B,  32'h13, 32'h00000080, 32'h0,        0));
      va.push_back(mk(0, C_W,  32'h10, 32'h0,        32'h80ADBEEF, 0));
      va.push_back(mk(0, C_B,  32'h13, 32'h0,        32'hFFFFFF80, 0));
      va.push_back(mk(0, C_BU, 32'h13, 32'h0,        32'h00000080, 0));
      va.push_back(mk(1, C_W,  32'h20, 32'h55667788, 32'h0,        0));
      va.push_back(mk(1, C_H,  32'h22, 32'h00001234, 32'h0,        0));
      va.push_back(mk(0, C_H,  32'h22, 32'h0,        32'h00001234, 0));
      va.push_back(mk(0, C_HU, 32'h20, 32'h0,        32'h00007788, 0));
      va.push_back(mk(0, C_W,  32'h20, 32'h0,        32'h12347788, 0));
      va.push_back(mk(1, C_H,  32'h20, 32'hFFFF9ABC, 32'h0,        0));
      va.push_back(mk(0, C_H,  32'h20, 32'h0,        32'hFFFF9ABC, 0));
      va.push_back(mk(0, C_BU, 32'h21, 32'h0,        32'h0000009A, 0));
      va.push_back(mk(0, C_B,  32'h21, 32'h0,        32'hFFFFFF9A, 0));
      va.push_back(mk(1, C_W,  32'h30, 32'hA5A5A5A5, 32'h0,        0));
`ifdef DM_MISALIGN_ERR_EN
      va.push_back(mk(0, C_H,  32'h11, 32'h0,        32'h0,        1));
      va.push_back(mk(1, C_H,  32'h11, 32'h00005A5A, 32'h0,        1));
      va.push_back(mk(0, C_W,  32'h10, 32'h0,        32'h80ADBEEF, 0));
      va.push_back(mk(1, C_W,  32'h32, 32'h11111111, 32'h0,        1));
      va.push_back(mk(0, C_W,  32'h30, 32'h0,        32'hA5A5A5A5, 0));
      va.push_back(mk(0, C_W,  32'h33, 32'h0,        32'h0,        1));
`else
      va.push_back(mk(0, C_H,  32'h11, 32'h0,        32'hFFFFBEEF, 0));
      va.push_back(mk(1, C_H,  32'h11, 32'h00005A5A, 32'h0,        0));
      va.push_back(mk(0, C_W,  32'h10, 32'h0,        32'h80AD5A5A, 0));
      va.push_back(mk(1, C_W,  32'h32, 32'h11111111, 32'h0,        0));
      va.push_back(mk(0, C_W,  32'h30, 32'h0,        32'h11111111, 0));
      va.push_back(mk(0, C_W,  32'h33, 32'h0,        32'h11111111, 0));
`endif
      va.push_back(mk(0, 3'b011, 32'h10, 32'h0,      32'h0,        1));
      va.push_back(mk(0, 3'b111, 32'h10, 32'h0,      32'h0,        1));
      va.push_back(mk(1, C_BU, 32'h10, 32'h000000FF, 32'h0,        1));
      va.push_back(mk(1, C_HU, 32'h10, 32'h0000FFFF, 32'h0,        1));
      va.push_back(mk(1, 3'b110, 32'h10, 32'h0,      32'h0,        1));
`ifdef DM_MISALIGN_ERR_EN
      va.push_back(mk(0, C_W,  32'h10, 32'h0,        32'h80ADBEEF, 0));
`else
      va.push_back(mk(0, C_W,  32'h10, 32'h0,        32'h80AD5A5A, 0));
`endif
      va.push_back(mk(1, C_W,  32'h40, 32'h13579BDF, 32'h0,        0));

      vb.push_back(mk(1, C_W,  32'h1000, 32'h0BADCAFE, 32'h0,        0));
      vb.push_back(mk(0, C_W,  32'h0,    32'h0,        32'h0BADCAFE, 0));
      vb.push_back(mk(1, C_B,  32'h1003, 32'h00000077, 32'h0,        0));
      vb.push_back(mk(0, C_W,  32'h0,    32'h0,        32'h77ADCAFE, 0));
      vb.push_back(mk(1, C_W,  32'h4,    32'h24681357, 32'h0,        0));

      // ---------------- reset values ----------------
      repeat (3) @(negedge clk);
      checks++;
      if (a_if.ready !== 1'b0 || a_if.err !== 1'b0 || a_if.DataRd !== 32'd0 ||
          b_if.ready !== 1'b0 || b_if.err !== 1'b0 || b_if.DataRd !== 32'd0) begin
         errors++;
         $display("FAIL reset_values got a:%b/%b/%h b:%b/%b/%h want all 0",
                  a_if.ready, a_if.err, a_if.DataRd, b_if.ready, b_if.err, b_if.DataRd);
      end
      rst_n = 1'b1;

      // ---------------- table-driven ----------------
      for (int i = 0; i < va.size(); i++) txn(1'b0, va[i], 3);
      for (int i = 0; i < vb.size(); i++) txn(1'b1, vb[i], 1);

      // ---------------- reset during RESP (async clear) ----------------
      @(negedge clk);
      a_if.req = 1'b1; a_if.DmWr = 1'b0; a_if.DmCtrl = C_W; a_if.Address = 32'h40;
      e.d = 32'h13579BDF; e.e = 1'b0;
      sb_a.push_back(e);
      n = 0;
      do begin @(negedge clk); n++; end while (!a_if.ready && n < 20);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (a_if.ready !== 1'b0 || a_if.DataRd !== 32'd0 || a_if.err !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_resp got ready=%b DataRd=%h err=%b want 0",
                  a_if.ready, a_if.DataRd, a_if.err);
      end
      a_if.req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // ---------------- reset during WAIT drops the store ----------------
      @(negedge clk);
      a_if.req = 1'b1; a_if.DmWr = 1'b1; a_if.DmCtrl = C_W; a_if.Address = 32'h40;
      a_if.DataWr = 32'hCAFEF00D;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (a_if.ready !== 1'b0 || a_if.DataRd !== 32'd0 || a_if.err !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_wait got ready=%b DataRd=%h err=%b want 0",
                  a_if.ready, a_if.DataRd, a_if.err);
      end
      a_if.req = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      txn(1'b0, mk(0, C_W, 32'h40, 32'h0, 32'h13579BDF, 0), 3);

      // ---------------- zero-wait back-to-back held request ----------------
      e.d = 32'h24681357; e.e = 1'b0;
      @(negedge clk);
      b_if.req = 1'b1; b_if.DmWr = 1'b0; b_if.DmCtrl = C_W; b_if.Address = 32'h4;
      for (int i = 0; i < 5; i++) sb_b.push_back(e);
      pulses = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (b_if.ready) pulses++;
         checks++;
         if (b_if.ready !== logic'(i % 2)) begin
            errors++;
            $display("FAIL b2b_pattern cycle=%0d got ready=%b want %0d", i, b_if.ready, i % 2);
         end
      end
      b_if.req = 1'b0;
      checks++;
      if (pulses != 5) begin
         errors++;
         $display("FAIL b2b_pulses got %0d want 5", pulses);
      end

      repeat (4) @(negedge clk);
      checks++;
      if (sb_a.size() != 0 || sb_b.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got a=%0d b=%0d pending want 0", sb_a.size(), sb_b.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_dm_responder

`default_nettype wire
